// File: rtl/cpu_pkg.sv
// Shared datapath constants for the MIPS CPU, plus the address range test
// that every word-addressed store needs.
package cpu_pkg;

    localparam int DATA_W            = 32;
    localparam int ADDR_W            = 32;
    localparam int MEM_DEPTH_DEFAULT = 256;

    // True when no address bit above the index field is set.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int                idx_bits);
        return (addr >> idx_bits) == '0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-wide register file: asynchronous clear of every word, one synchronous
// write port and one combinational read port.
module mem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH     = MEM_DEPTH_DEFAULT,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_idx,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [ADDR_BITS-1:0] rd_idx,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is built from resettable flops rather than a RAM
        // macro, because every word must read as zero the moment reset rises.
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            // NOTE: non-blocking update so the read port shows old data until
            // the edge that performs the write.
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/memory.sv
// Unified word-addressed instruction/data memory: range check, write gating
// and a zero-filled combinational read in front of the register file.
module memory
    import cpu_pkg::*;
#(
    parameter int DEPTH     = MEM_DEPTH_DEFAULT,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              writeEnable,
    output logic [DATA_W-1:0] MemData
);

    logic                 in_range;
    logic [ADDR_BITS-1:0] word_idx;
    logic                 wr_en;
    logic [DATA_W-1:0]    rd_word;

    always_comb begin
        in_range = addr_in_range(Address, ADDR_BITS);
        word_idx = Address[ADDR_BITS-1:0];
        // Out-of-range addresses must not alias onto the low index bits.
        wr_en    = writeEnable && in_range && !Reset;
        MemData  = (in_range && !Reset) ? rd_word : '0;
    end

    mem_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk     (Clk),
        .rst     (Reset),
        .wr_en   (wr_en),
        .wr_idx  (word_idx),
        .wr_data (writeData),
        .rd_idx  (word_idx),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus pushes expected reads, a monitor on
// the falling edge pops and compares them against MemData.
module tb_memory;

    localparam int unsigned DEPTH = 256;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] MemData;

    int checks = 0;
    int errors = 0;

    sb_entry_t   sb_q[$];
    logic [31:0] model [DEPTH];

    memory #(.DEPTH(DEPTH)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Address     (Address),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .MemData     (MemData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < DEPTH) return model[a[7:0]];
        return 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic expect_now(input string name, input logic [31:0] a);
        sb_entry_t e;
        e.name = name;
        e.exp  = model_read(a);
        sb_q.push_back(e);
    endtask

    // One clock cycle of traffic; inputs change just after a rising edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input string name);
        Address     = a;
        writeData   = d;
        writeEnable = w;
        expect_now(name, a);
        @(posedge Clk);
        if (!Reset && w && a < DEPTH) model[a[7:0]] = d;
        #1;
    endtask

    // Monitor: the memory is always ready, so every queued read is checked
    // at the falling edge of the cycle in which it was presented.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge Clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, MemData, e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;

        model_clear();
        Reset       = 1'b1;
        Address     = 32'h0F;
        writeData   = 32'h0;
        writeEnable = 1'b0;
        @(posedge Clk);
        #1;

        // Reset held: defined zero output.
        expect_now("reset_hold", 32'h0F);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_op(i, 32'h0, 1'b0, "sweep_after_reset");

        // Write then read: old data before the edge, new data after.
        do_op(32'h0F, 32'hFFFF_FFFF, 1'b1, "wr_before_edge");
        do_op(32'h0F, 32'h0, 1'b0, "rd_after_edge");
        do_op(32'h0F, 32'h0, 1'b0, "rd_held");

        // Overwrite and independence.
        do_op(32'h0F, 32'hF0F0_F0F0, 1'b1, "overwrite_0f");
        do_op(32'hFF, 32'hFFFF_0000, 1'b1, "write_ff");
        do_op(32'h0F, 32'h0, 1'b0, "read_0f");
        do_op(32'hFF, 32'h0, 1'b0, "read_ff");
        do_op(32'h0E, 32'h0, 1'b0, "read_0e");

        // Write disabled leaves contents alone.
        do_op(32'h0F, 32'h1111_1111, 1'b0, "we_low");
        do_op(32'h0F, 32'h0, 1'b0, "we_low_after");

        // Successive writes to one word: the last wins.
        do_op(32'h05, 32'hAAAA_0001, 1'b1, "back2back_1");
        do_op(32'h05, 32'hAAAA_0002, 1'b1, "back2back_2");
        do_op(32'h05, 32'h0, 1'b0, "back2back_read");

        // Out of range: ignored, no aliasing onto low index bits.
        do_op(32'h100, 32'hDEAD_BEEF, 1'b1, "oor_write");
        do_op(32'h100, 32'h0, 1'b0, "oor_read");
        do_op(32'h000, 32'h0, 1'b0, "oor_no_alias_0");
        do_op(32'h8000_00FF, 32'h1234_5678, 1'b1, "oor_high_write");
        do_op(32'h0FF, 32'h0, 1'b0, "oor_no_alias_ff");

        // Asynchronous reset between edges with a write pending.
        Address     = 32'h0F;
        writeData   = 32'h5555_AAAA;
        writeEnable = 1'b1;
        #2;
        Reset = 1'b1;
        model_clear();
        expect_now("rst_async_clear", 32'h0F);
        @(posedge Clk);
        #1;
        expect_now("rst_write_blocked", 32'h0F);
        @(posedge Clk);
        #1;
        Reset       = 1'b0;
        writeEnable = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_op(i, 32'h0, 1'b0, "sweep_after_rst_pulse");

        // Randomised traffic against the array model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = $urandom_range(0, DEPTH + 15);
            d = $urandom();
            do_op(a, d, 1'($urandom_range(0, 1)), "random");
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge Clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory.md
# memory

Unified word-addressed data/instruction memory for the MIPS CPU datapath. It holds DEPTH 32-bit words, writes on the rising clock edge when enabled and returns the addressed word combinationally. It sits between the CPU datapath (address/write-data/write-enable sources) and the instruction/memory-data registers that capture MemData.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; power of two, minimum 16.
- ADDR_BITS, $clog2(DEPTH), index bits taken from Address.

Ports:
- Clk, input, 1, the single clock; all writes occur on its rising edge.
- Reset, input, 1, asynchronous, active-high; clears the whole array.
- Address, input, 32, word index (not byte address); the word selected is Address[ADDR_BITS-1:0].
- writeData, input, 32, data written at the selected word.
- writeEnable, input, 1, active-high write strobe, sampled on the rising Clk edge.
- MemData, output, 32, word at the selected address (combinational read).

## Operation
- Storage: DEPTH × 32-bit register array, word granularity only; no byte or half-word lanes.
- In range means Address[31:ADDR_BITS] == 0.
- Write: on posedge Clk with Reset low, writeEnable=1 and Address in range, mem[Address[ADDR_BITS-1:0]] <= writeData. Out-of-range writes are ignored, with no aliasing.
- Read: MemData = mem[index] when Address is in range, else 32'h0000_0000. The read is purely combinational from Address and array contents and does not depend on writeEnable.
- Reset: while Reset=1, every word is 0, MemData=0, and writes are blocked. Release is asynchronous; the first write can occur on the first posedge after Reset falls.
- No X propagation: after reset every location reads a defined value.

## Timing
- Read latency is 0 cycles. MemData follows Address within the same cycle.
- Write latency is 1 edge. The new value appears on MemData just after the posedge that performs the write. Before that edge, MemData shows the old contents.
- Read-during-write to the same address returns the old data until the edge, then the new data. This is write-first after the edge and old-data before it.
- Consecutive writes to the same address on successive edges: the last one wins.
- Reset asserted mid-cycle, including between a write setup and its edge, clears immediately. The pending write is lost.
- No handshake. The memory is always ready, and the datapath holds its control for the full cycle.

## Structure
- Shared package cpu_pkg holds DATA_W=32, ADDR_W=32 and MEM_DEPTH_DEFAULT=256. Other datapath blocks reuse these.
- Sub-modules:
  - An optional sub-module, mem_array, holds the register file with its async clear and sync write.
  - The top level holds the range check and the read multiplexer with zero-fill.
- No other sub-modules.

## Test plan
1. Reset: assert Reset with Address=0x0F → MemData=0x00000000. Release Reset and sweep all addresses → every read is 0.
2. Write then read: writeEnable=1, writeData=0xFFFFFFFF, Address=0x0F for one cycle. Then writeEnable=0, same address → MemData=0xFFFFFFFF right after the edge and held. Before the edge, MemData=0.
3. Overwrite plus independence:
   - Write 0xF0F0F0F0 to 0x0F, then 0xFFFF0000 to 0xFF.
   - Read 0x0F → 0xF0F0F0F0; read 0xFF → 0xFFFF0000.
   - Read 0x0E → 0.
4. Write disabled: writeEnable=0, writeData=0x11111111, Address=0x0F → contents unchanged, and MemData keeps its previous value.
5. Out of range with DEPTH=256: write 0xDEADBEEF to Address=0x100 → MemData=0 at 0x100, and address 0x000 is not modified.
6. Async reset mid-operation: after test 3, pulse Reset between clock edges → MemData drops to 0 immediately, without waiting for a clock. A write presented during reset does not take effect, and all locations read 0 afterward.
